// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: FSM state encoding and the host-memory access
// routines mm_read/mm_write, which keep the DPI-C call signatures so other ports can reuse them.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  longint      mm_mem [longint];
  int unsigned mm_calls = 0;

  function automatic void mm_read(input longint addr, output longint data);
    mm_calls++;
    data = mm_mem.exists(addr) ? mm_mem[addr] : 64'd0;
  endfunction

  function automatic void mm_write(input longint addr, input longint data);
    mm_calls++;
    mm_mem[addr] = data;
  endfunction

  // Side-effect-free look at host memory; does not count as an access.
  function automatic longint mm_peek(input longint addr);
    return mm_mem.exists(addr) ? mm_mem[addr] : 64'd0;
  endfunction

endpackage

// File: rtl/dmem_strobe_merge.sv
// Expands byte strobes into a 64-bit byte mask plus lane-positioned store data,
// so a read-modify-write merges as (old & ~mask_o) | data_o.
module dmem_strobe_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  output logic [63:0]             mask_o,
  output logic [63:0]             data_o
);

  always_comb begin
    mask_o = '0;
    for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
      mask_o[8*b +: 8] = {8{wstrb_i[b]}};
    end
  end

  assign data_o = 64'(wdata_i) & mask_o;

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data-memory port: one request in flight, programmable latency,
// byte-strobed stores with read-modify-write against host memory.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic [1:0]              status
);

  localparam int         NB   = DATA_WIDTH / 8;
  localparam int         OFFW = $clog2(NB);
  localparam logic [7:0] LAST = 8'(LATENCY - 1);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("data_memory_ctrl: DATA_WIDTH must be 32 or 64");
  end
  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("data_memory_ctrl: LATENCY must be in 1..255");
  end

  dmem_state_e           state_q, state_d;
  logic [7:0]            cnt_q;
  logic                  wr_q, err_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [NB-1:0]         wstrb_q;
  logic [63:0]           wmask, wdata_pos;
  logic                  accept, access, misaligned;

  assign accept     = (state_q == IDLE) && req_valid;
  assign access     = (state_q == BUSY) && (cnt_q == LAST);
  assign misaligned = |addr_q[OFFW-1:0];

  dmem_strobe_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .mask_o  (wmask),
    .data_o  (wdata_pos)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid)    state_d = BUSY;
      BUSY:    if (cnt_q == LAST) state_d = RESP;
      RESP:    if (resp_ready)   state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    status     = state_q;
  end

  // Host-memory access happens inside the edge that leaves BUSY.
  always_ff @(posedge clk or posedge reset) begin
    longint word;
    if (reset) begin
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        cnt_q   <= '0;
        rdata_q <= '0;
        err_q   <= 1'b0;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (access) begin
        if (misaligned) begin
          err_q <= 1'b1;
        end else if (!wr_q) begin
          mm_read({32'b0, addr_q}, word);
          rdata_q <= word[DATA_WIDTH-1:0];
        end else if (&wstrb_q) begin
          mm_write({32'b0, addr_q}, 64'(wdata_q));
        end else if (|wstrb_q) begin
          mm_read({32'b0, addr_q}, word);
          mm_write({32'b0, addr_q}, (word & ~wmask) | wdata_pos);
        end
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: a 32-bit/LATENCY=3 and a 64-bit/LATENCY=1 instance
// sharing host memory, checked against a per-byte reference memory.
module tb_data_memory_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel64 = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;

  logic        rr32, rv32, err32, rr64, rv64, err64;
  logic [31:0] rd32;
  logic [63:0] rd64;
  logic [1:0]  st32, st64;

  logic        o_req_ready, o_resp_valid, o_err;
  logic [63:0] o_rdata;
  logic [1:0]  o_status;

  int n_tests = 0;
  int n_fail  = 0;

  longint ref_mem [longint];

  always #5 clk = ~clk;

  data_memory_ctrl #(.DATA_WIDTH(32), .LATENCY(3)) u_dut32 (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel64), .req_ready(rr32),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .req_wstrb(req_wstrb[3:0]), .resp_valid(rv32), .resp_ready(resp_ready),
    .resp_rdata(rd32), .resp_err(err32), .status(st32)
  );

  data_memory_ctrl #(.DATA_WIDTH(64), .LATENCY(1)) u_dut64 (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel64), .req_ready(rr64),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .resp_valid(rv64), .resp_ready(resp_ready),
    .resp_rdata(rd64), .resp_err(err64), .status(st64)
  );

  assign o_req_ready  = sel64 ? rr64  : rr32;
  assign o_resp_valid = sel64 ? rv64  : rv32;
  assign o_err        = sel64 ? err64 : err32;
  assign o_rdata      = sel64 ? rd64  : {32'b0, rd32};
  assign o_status     = sel64 ? st64  : st32;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: each host address holds one 64-bit word; bytes are replaced individually.
  task automatic model(input logic w64, input logic wr, input logic [31:0] a,
                       input logic [63:0] wd, input logic [7:0] ws,
                       output logic [63:0] rd, output logic err, output int calls);
    int          nb;
    int          nset;
    longint      k;
    logic [63:0] w;
    nb   = w64 ? 8 : 4;
    k    = longint'({32'b0, a});
    w    = ref_mem.exists(k) ? ref_mem[k] : 64'd0;
    rd   = '0;
    err  = 1'b0;
    calls = 0;
    nset = 0;
    if ((a % nb) != 0) begin
      err = 1'b1;
    end else if (!wr) begin
      calls = 1;
      rd = (nb == 8) ? w : {32'b0, w[31:0]};
    end else begin
      for (int i = 0; i < nb; i++) begin
        if (ws[i]) begin
          w[8*i +: 8] = wd[8*i +: 8];
          nset++;
        end
      end
      if (nset == nb && nb == 4) w[63:32] = '0;
      calls = (nset == 0) ? 0 : (nset == nb) ? 1 : 2;
      if (nset > 0) ref_mem[k] = w;
    end
  endtask

  task automatic do_req(input logic w64, input logic wr, input logic [31:0] a,
                        input logic [63:0] wd, input logic [7:0] ws,
                        output logic [63:0] rd, output logic err, output int lat,
                        output int calls);
    int unsigned c0;
    int          waitc;
    @(negedge clk);
    sel64 = w64; req_write = wr; req_addr = a; req_wdata = wd; req_wstrb = ws;
    req_valid = 1'b1; resp_ready = 1'b1;
    waitc = 0;
    while (!o_req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 50) check("req_ready_timeout", 64'd0, 64'd1);
    c0 = mm_calls;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = ~wr; req_addr = $urandom;
    req_wdata = {$urandom, $urandom}; req_wstrb = 8'($urandom);
    lat = 0;
    while (!o_resp_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    rd    = o_rdata;
    err   = o_err;
    calls = int'(mm_calls - c0);
    @(posedge clk); #1;
    check("req_ready_after_resp", {63'b0, o_req_ready}, 64'd1);
  endtask

  task automatic run_req(input string tag, input logic w64, input logic wr,
                         input logic [31:0] a, input logic [63:0] wd, input logic [7:0] ws,
                         output logic [63:0] rd);
    logic [63:0] erd;
    logic        eerr, gerr;
    int          ecalls, gcalls, lat;
    model(w64, wr, a, wd, ws, erd, eerr, ecalls);
    do_req(w64, wr, a, wd, ws, rd, gerr, lat, gcalls);
    check({tag, "_rdata"}, rd, erd);
    check({tag, "_err"}, {63'b0, gerr}, {63'b0, eerr});
    check({tag, "_latency"}, 64'(lat), w64 ? 64'd1 : 64'd3);
    check({tag, "_calls"}, 64'(gcalls), 64'(ecalls));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  rd;
    int unsigned  c0;
    int           waitc;

    // Values held while reset is asserted.
    repeat (2) @(posedge clk);
    #1;
    check("rst_status", 64'(o_status), 64'd0);
    check("rst_req_ready", {63'b0, o_req_ready}, 64'd1);
    check("rst_resp_valid", {63'b0, o_resp_valid}, 64'd0);
    check("rst_rdata", o_rdata, 64'd0);
    check("rst_err", {63'b0, o_err}, 64'd0);
    @(negedge clk) reset = 1'b0;

    // Reset in the middle of BUSY abandons a pending store.
    @(negedge clk);
    sel64 = 1'b0; req_write = 1'b1; req_addr = 32'h300; req_wdata = 64'hCAFEF00D;
    req_wstrb = 8'hF; req_valid = 1'b1;
    c0 = mm_calls;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("midbusy_status", 64'(o_status), 64'd0);
    check("midbusy_req_ready", {63'b0, o_req_ready}, 64'd1);
    check("midbusy_resp_valid", {63'b0, o_resp_valid}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    check("midbusy_calls", 64'(mm_calls - c0), 64'd0);
    check("midbusy_mem", mm_peek(64'h300), 64'd0);

    // Directed 32-bit sequence.
    run_req("st_full", 1'b0, 1'b1, 32'h100, 64'hDEADBEEF, 8'hF, rd);
    run_req("ld_full", 1'b0, 1'b0, 32'h100, 64'h0, 8'h0, rd);
    check("ld_full_const", rd, 64'hDEADBEEF);
    run_req("st_part", 1'b0, 1'b1, 32'h100, 64'h11223344, 8'b0101, rd);
    run_req("ld_part", 1'b0, 1'b0, 32'h100, 64'h0, 8'h0, rd);
    check("ld_part_const", rd, 64'hDE22BE44);
    run_req("ld_mis", 1'b0, 1'b0, 32'h102, 64'h0, 8'h0, rd);
    run_req("st_zero", 1'b0, 1'b1, 32'h100, 64'hFFFFFFFF, 8'h0, rd);
    check("st_zero_mem", mm_peek(64'h100), 64'hDE22BE44);

    // Response backpressure with an ignored request pulse.
    @(negedge clk);
    sel64 = 1'b0; req_write = 1'b0; req_addr = 32'h100; req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    waitc = 0;
    while (!o_resp_valid && waitc < 300) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("bp_latency", 64'(waitc), 64'd3);
    for (int cyc = 0; cyc < 5; cyc++) begin
      check("bp_resp_valid", {63'b0, o_resp_valid}, 64'd1);
      check("bp_status", 64'(o_status), 64'd2);
      check("bp_req_ready", {63'b0, o_req_ready}, 64'd0);
      check("bp_rdata", o_rdata, 64'hDE22BE44);
      @(negedge clk);
      if (cyc == 1) begin
        req_write = 1'b1; req_wdata = 64'h55555555; req_wstrb = 8'hF; req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    @(negedge clk) resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_status", 64'(o_status), 64'd0);
    @(posedge clk); #1;
    check("bp_pulse_ignored", 64'(o_status), 64'd0);
    check("bp_mem", mm_peek(64'h100), 64'hDE22BE44);

    // Directed 64-bit sequence.
    run_req("st64_part", 1'b1, 1'b1, 32'h200, 64'h0123456789ABCDEF, 8'hF0, rd);
    run_req("ld64", 1'b1, 1'b0, 32'h200, 64'h0, 8'h0, rd);
    check("ld64_const", rd, 64'h0123456700000000);
    run_req("ld64_mis", 1'b1, 1'b0, 32'h204, 64'h0, 8'h0, rd);
    check("ld64_mis_err_rdata", rd, 64'd0);

    // Randomized mix over a shared address pool.
    for (int n = 0; n < 80; n++) begin
      logic        w64, wr;
      logic [31:0] a;
      logic [63:0] wd;
      logic [7:0]  ws;
      int          pick;
      w64 = 1'($urandom_range(0, 1));
      wr  = ($urandom_range(0, 9) < 6);
      a   = 32'h400 + 32'(8 * $urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 7));
      wd  = {$urandom, $urandom};
      pick = $urandom_range(0, 3);
      ws  = (pick == 0) ? 8'h00 : (pick == 1) ? (w64 ? 8'hFF : 8'h0F) : 8'($urandom);
      run_req("rand", w64, wr, a, wd, ws, rd);
    end
    for (int k = 0; k < 8; k++) begin
      longint key;
      key = longint'(64'h400 + 64'(8 * k));
      check("final_mem", mm_peek(key), ref_mem.exists(key) ? ref_mem[key] : 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
